// File: rtl/ysyx_25020037_icache_pkg.sv
// Shared geometry, state encoding and line payload for the direct-mapped instruction cache.
package ysyx_25020037_icache_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INDEX_W = 4;
    localparam int unsigned TAG_W   = XLEN - INDEX_W - 2;
    localparam int unsigned LINES   = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'b00,
        IC_LOOKUP = 2'b01,
        IC_REFILL = 2'b10
    } ic_state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } ic_line_t;

endpackage

// File: rtl/ysyx_25020037_icache_if.sv
// IFU <-> icache lookup, fill-snoop and counter signals.
interface ysyx_25020037_icache_if;
    import ysyx_25020037_icache_pkg::*;

    logic            icache_req;
    logic [XLEN-1:0] addr;
    logic            fence_i;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic            icache_hit;
    logic [XLEN-1:0] icache_data;
    logic            mem_req;
    logic            icache_ready;
    logic [XLEN-1:0] hit_cnt;
    logic [XLEN-1:0] miss_cnt;

    modport master (
        output icache_req, addr, fence_i, mem_rdata, mem_ready,
        input  icache_hit, icache_data, mem_req, icache_ready, hit_cnt, miss_cnt
    );

    modport slave (
        input  icache_req, addr, fence_i, mem_rdata, mem_ready,
        output icache_hit, icache_data, mem_req, icache_ready, hit_cnt, miss_cnt
    );

endinterface

// File: rtl/ysyx_25020037_icache_array.sv
// Valid/tag/data line storage: one combinational read port, one write port, flash invalidate.
module ysyx_25020037_icache_array
    import ysyx_25020037_icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output ic_line_t           rd_line,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [XLEN-1:0]    wr_data,
    input  logic               flush
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [XLEN-1:0]  data_q [LINES];

    // A fill in the same cycle as a flush keeps its own line valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            if (flush) valid_q <= '0;
            if (wr_en) valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_line = '{valid: valid_q[rd_idx], tag: tag_q[rd_idx], data: data_q[rd_idx]};

endmodule

// File: rtl/ysyx_25020037_icache.sv
// Direct-mapped one-word-line icache: lookup FSM, refill snoop and hit/miss counters.
module ysyx_25020037_icache
    import ysyx_25020037_icache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    ysyx_25020037_icache_if.slave   bus
);

    ic_state_e          state_q, state_d;
    logic [XLEN-1:0]    req_addr_q;
    logic [XLEN-1:0]    hit_cnt_q, miss_cnt_q;
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    ic_line_t           line_c;
    logic               hit_c;
    logic               fill_c;
    logic               icache_hit_c, mem_req_c, icache_ready_c;
    logic [XLEN-1:0]    icache_data_c;
    logic               unused_addr_bits;

    assign req_idx          = req_addr_q[INDEX_W+1:2];
    assign req_tag          = req_addr_q[XLEN-1:INDEX_W+2];
    assign unused_addr_bits = ^req_addr_q[1:0];

    ysyx_25020037_icache_array u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (req_idx),
        .rd_line (line_c),
        .wr_en   (fill_c),
        .wr_idx  (req_idx),
        .wr_tag  (req_tag),
        .wr_data (bus.mem_rdata),
        .flush   (bus.fence_i)
    );

    assign hit_c = line_c.valid && (line_c.tag == req_tag);

    // Next state and Moore-style handshake decode.
    always_comb begin
        state_d        = state_q;
        icache_hit_c   = 1'b0;
        icache_data_c  = '0;
        mem_req_c      = 1'b0;
        icache_ready_c = 1'b0;
        fill_c         = 1'b0;
        unique case (state_q)
            IC_IDLE: begin
                if (bus.icache_req) state_d = IC_LOOKUP;
            end
            IC_LOOKUP: begin
                if (hit_c) begin
                    icache_hit_c  = 1'b1;
                    icache_data_c = line_c.data;
                    state_d       = IC_IDLE;
                end else begin
                    mem_req_c = 1'b1;
                    state_d   = IC_REFILL;
                end
            end
            IC_REFILL: begin
                icache_ready_c = 1'b1;
                if (bus.mem_ready) begin
                    fill_c  = 1'b1;
                    state_d = IC_IDLE;
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IC_IDLE;
            req_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IC_IDLE && bus.icache_req) req_addr_q <= bus.addr;
            if (state_q == IC_LOOKUP) begin
                if (hit_c) hit_cnt_q  <= hit_cnt_q + XLEN'(1);
                else       miss_cnt_q <= miss_cnt_q + XLEN'(1);
            end
        end
    end

    assign bus.icache_hit   = icache_hit_c;
    assign bus.icache_data  = icache_data_c;
    assign bus.mem_req      = mem_req_c;
    assign bus.icache_ready = icache_ready_c;
    assign bus.hit_cnt      = hit_cnt_q;
    assign bus.miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_25020037_icache.sv
// Self-checking bench: directed scenarios plus random fetch/fence/noise against a line-array model.
module tb_ysyx_25020037_icache;

    logic clk;
    logic rst;

    ysyx_25020037_icache_if bus ();

    ysyx_25020037_icache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: what each of the 16 lines holds, plus expected counters.
    bit          mv [16];
    logic [25:0] mt [16];
    logic [31:0] md [16];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_hit"},   32'(bus.icache_hit),   32'd0);
        check({tag, "_req"},   32'(bus.mem_req),      32'd0);
        check({tag, "_ready"}, 32'(bus.icache_ready), 32'd0);
        check({tag, "_data"},  bus.icache_data,       32'd0);
    endtask

    task automatic check_counters();
        check("hit_cnt",  bus.hit_cnt,  exp_hits);
        check("miss_cnt", bus.miss_cnt, exp_misses);
    endtask

    // One complete fetch; stall >= 1 cycles of REFILL before mem_ready.
    task automatic fetch(input logic [31:0] a, input logic [31:0] fd, input int stall,
                         input bit fence_at_lookup, input bit fence_at_fill);
        int          idx;
        logic [25:0] tg;
        bit          exp_hit;
        idx = int'(a[5:2]);
        tg  = a[31:6];
        @(negedge clk);
        bus.icache_req = 1'b1;
        bus.addr       = a;
        @(negedge clk);
        bus.icache_req = 1'b0;
        bus.addr       = $urandom;
        exp_hit = mv[idx] && (mt[idx] == tg);
        check("lookup_hit",   32'(bus.icache_hit),   32'(exp_hit));
        check("lookup_req",   32'(bus.mem_req),      32'(!exp_hit));
        check("lookup_ready", 32'(bus.icache_ready), 32'd0);
        if (exp_hit) check("lookup_data", bus.icache_data, md[idx]);
        if (exp_hit) exp_hits++; else exp_misses++;
        if (fence_at_lookup) begin
            bus.fence_i = 1'b1;
            model_clear();
        end
        if (exp_hit) begin
            @(negedge clk);
            bus.fence_i = 1'b0;
            check_idle_outputs("after_hit");
        end else begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                bus.fence_i = 1'b0;
                check("refill_ready", 32'(bus.icache_ready), 32'd1);
                check("refill_hit",   32'(bus.icache_hit),   32'd0);
                check("refill_req",   32'(bus.mem_req),      32'd0);
                bus.icache_req = 1'($urandom);
                bus.addr       = $urandom;
            end
            bus.icache_req = 1'b0;
            bus.mem_rdata  = fd;
            bus.mem_ready  = 1'b1;
            bus.fence_i    = fence_at_fill;
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.fence_i   = 1'b0;
            bus.mem_rdata = $urandom;
            if (fence_at_fill) model_clear();
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = fd;
            check_idle_outputs("after_fill");
        end
        check_counters();
    endtask

    task automatic fence_pulse();
        @(negedge clk);
        bus.fence_i = 1'b1;
        @(negedge clk);
        bus.fence_i = 1'b0;
        model_clear();
        check_idle_outputs("fence");
    endtask

    task automatic idle_noise();
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = $urandom;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check_idle_outputs("noise");
        check_counters();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 6)
                          | (32'($urandom_range(0, 15)) << 2)
                          | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        logic [31:0] a;
        int          op;
        rst            = 1'b0;
        bus.icache_req = 1'b0;
        bus.addr       = '0;
        bus.fence_i    = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        model_clear();
        exp_hits   = '0;
        exp_misses = '0;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check_counters();
        rst = 1'b1;

        // Cold miss, then hit.
        fetch(32'h8000_0000, 32'h0000_0413, 3, 1'b0, 1'b0);
        fetch(32'h8000_0000, 32'h0, 1, 1'b0, 1'b0);
        check("hit_data_known", md[0], 32'h0000_0413);

        // Conflict eviction on index 1.
        fetch(32'h8000_0004, $urandom, 1, 1'b0, 1'b0);
        fetch(32'h8000_0044, $urandom, 2, 1'b0, 1'b0);
        fetch(32'h8000_0004, $urandom, 1, 1'b0, 1'b0);

        // Fence in IDLE, then fence coincident with a fill of line 3.
        fetch(32'h8000_0008, $urandom, 1, 1'b0, 1'b0);
        fence_pulse();
        fetch(32'h8000_0008, $urandom, 1, 1'b0, 1'b0);
        fetch(32'h8000_000C, $urandom, 1, 1'b0, 1'b1);
        fetch(32'h8000_000C, $urandom, 1, 1'b0, 1'b0);
        fetch(32'h8000_0008, $urandom, 1, 1'b0, 1'b0);

        // Fence during a hitting lookup: the hit still lands.
        fetch(32'h8000_0008, $urandom, 1, 1'b1, 1'b0);
        fetch(32'h8000_0008, $urandom, 1, 1'b0, 1'b0);

        // Ignored mem_ready in IDLE.
        idle_noise();
        fetch(32'h8000_0008, $urandom, 1, 1'b0, 1'b0);

        // Stalled refill interrupted by reset.
        a = 32'h8000_0010;
        @(negedge clk);
        bus.icache_req = 1'b1;
        bus.addr       = a;
        @(negedge clk);
        bus.icache_req = 1'b0;
        check("stall_lookup_req", 32'(bus.mem_req), 32'd1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("stall_ready", 32'(bus.icache_ready), 32'd1);
        end
        rst = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        model_clear();
        exp_hits   = '0;
        exp_misses = '0;
        check_counters();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check_idle_outputs("post_reset_ready");
        fetch(a, $urandom, 2, 1'b0, 1'b0);
        fetch(a, $urandom, 1, 1'b0, 1'b0);

        // Random mix.
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            if (op < 8)
                fetch(rand_addr(), $urandom, int'($urandom_range(1, 4)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            else if (op == 8)
                fence_pulse();
            else
                idle_noise();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25020037_icache.md
Name: ysyx_25020037_icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IFU and the instruction memory path.
- On a request, it looks up the fetch PC and either returns the instruction in one cycle (hit) or asks the IFU to fetch from memory (miss).
- On a miss, it snoops the IFU's read-data channel and fills the line when the fetch completes.
- It also invalidates all lines on fence.i and provides hit/miss performance counters.

Parameters:
- INDEX_W, 4: index bits; line count = 2^INDEX_W (16 lines).
- TAG_W, 26: tag bits; always equals 32-INDEX_W-2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- icache_req  input  1  single-cycle lookup request from the IFU.
- addr  input  32  fetch PC; sampled when icache_req=1 in IDLE; bits [1:0] ignored.
- fence_i  input  1  single-cycle pulse that invalidates all lines.
- mem_rdata  input  32  IFU read data (the IFU's rdata).
- mem_ready  input  1  IFU read beat accepted with OKAY response; this is the fill strobe.
- icache_hit  output  1  lookup hit; valid in LOOKUP only.
- icache_data  output  32  hit instruction; valid when icache_hit=1.
- mem_req  output  1  miss indication; the IFU must start a memory fetch.
- icache_ready  output  1  cache is in REFILL and will capture mem_rdata on mem_ready.
- hit_cnt  output  32  count of hits.
- miss_cnt  output  32  count of misses.

Behaviour:
- Address split: index = addr[INDEX_W+1:2], tag = addr[31:INDEX_W+2].
- Storage per line: valid bit, tag register, 32-bit data register.
- Reset (rst=0, asynchronous):
  - state=IDLE; all valid bits 0; hit_cnt=miss_cnt=0; req_addr=0.
  - icache_hit, mem_req and icache_ready are 0; icache_data=0.
  - Tag and data arrays need not be reset.
- State IDLE:
  - icache_req=1: latch addr into req_addr, go to LOOKUP.
  - Otherwise stay in IDLE.
  - All handshake outputs are 0.
- State LOOKUP (exactly one cycle; outputs decoded from state, Moore style):
  - Hit means valid[idx] && tag[idx]==req_tag.
  - On hit: icache_hit=1, icache_data=data[idx], hit_cnt+1, next state IDLE.
  - On miss: mem_req=1, miss_cnt+1, next state REFILL.
  - icache_hit and mem_req are never both 1.
- State REFILL:
  - icache_ready=1 for the whole state.
  - On mem_ready=1: write data[idx]=mem_rdata, tag[idx]=req_tag, valid[idx]=1; next state IDLE.
  - Otherwise wait indefinitely; there is no timeout.
  - An error response never raises mem_ready, so the cache stays in REFILL; error recovery belongs to the IFU.
- Latency:
  - Request to hit response: 1 cycle (req at edge N, icache_hit high during cycle N+1).
  - Miss fill to next-request-ready: 1 cycle.
- icache_req outside IDLE is ignored (not queued).
- fence_i:
  - Clears every valid bit on the next edge in any state.
  - In LOOKUP, the lookup uses the pre-fence valid bits.
  - If fence_i and a REFILL write occur in the same cycle, the fill wins for its line (line ends valid); all other lines are cleared.
- mem_ready in IDLE or LOOKUP is ignored; no write happens.
- Counters wrap modulo 2^32.
- Reset asserted mid-REFILL: return to IDLE with all lines invalid; a later mem_ready is ignored.
- Replacement: a fill overwrites the line unconditionally (direct-mapped).

Decomposition:
- Shared package/header (ysyx_25020037_config.vh):
  - ICACHE_INDEX_W.
  - State encodings IC_IDLE=2'b00, IC_LOOKUP=2'b01, IC_REFILL=2'b10.
- Sub-module ysyx_25020037_icache_array holds the valid/tag/data storage:
  - One combinational read port.
  - One write port.
  - Flash-invalidate input.
- The FSM and counters stay in the top module.

Test Plan:
- Cold miss: reset, req addr=0x8000_0000 → LOOKUP gives mem_req=1, icache_hit=0, then icache_ready=1; mem_ready with mem_rdata=0x0000_0413 → IDLE; miss_cnt=1.
- Hit after fill: req addr=0x8000_0000 again → next cycle icache_hit=1, icache_data=0x0000_0413; hit_cnt=1; mem_req stays 0.
- Conflict eviction (INDEX_W=4): fill 0x8000_0004, then 0x8000_0044 (same index 1, different tag) → second is a miss; re-request 0x8000_0004 → miss.
- fence.i: fill 0x8000_0008, pulse fence_i in IDLE, req 0x8000_0008 → mem_req=1. Fence coincident with a fill of line 3 → line 3 hits afterwards, line 2 misses.
- Stalled refill and reset: miss, hold mem_ready=0 for 50 cycles → icache_ready stays 1. Assert rst=0 → outputs 0 immediately; after release, mem_ready=1 causes no write; req to the same address misses.
- Ignored inputs: icache_req during REFILL and mem_ready during IDLE → no state change, no array write, counters unchanged.
